mem_slot_arbiter: RTL
=====================

# mem_slot_arbiter

Sequences the two VLIW memory slots (slot 3 and slot 4) of an issued bundle onto the single data-memory port. It sits between the decode/execute pipeline registers and the data memory or cache. It latches both slots' requests and issues them in slot order, slot 3 then slot 4, with a req/ack handshake. It stalls the pipeline until both slots complete, then presents load results for writeback.

## Interface
Parameters:
- ADDR_W, 30: word-address width
- DATA_W, 32: data width

Ports:
- clk  in  1  clock; all state changes on posedge
- rstn  in  1  reset, asynchronous, active-low
- dec_mre3 / dec_mwe3  in  1  slot 3 load / store enable
- dec_mre4 / dec_mwe4  in  1  slot 4 load / store enable
- daddr3 / daddr4  in  ADDR_W  slot 3 / slot 4 address
- wdata3 / wdata4  in  DATA_W  store data, slot 3 / slot 4
- dec_rd3 / dec_rd4  in  7  load destination, slot 3 / slot 4
- arb_stall  out  1  holds the pipeline, bundle inputs frozen
- mem_req  out  1  request valid
- mem_we  out  1  1 = store, 0 = load
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  store data
- mem_ack  in  1  request accepted; for loads, mem_rdata is valid in the same cycle
- mem_rdata  in  DATA_W  load data
- wb_rd3 / wb_rd4  out  7  writeback destination; 0 = no write
- wb_memdata3 / wb_memdata4  out  DATA_W  load results

## Operation
- Slot active = mre | mwe. If both are set on one slot, the slot is a store.
- FSM states: IDLE, S3, S4, DONE.
- IDLE:
  - No slot active: arb_stall = 0 and the state stays IDLE.
  - Any slot active: arb_stall = 1 (combinational from the inputs). Latch we, addr, wdata, rd and active for both slots. Next state is S3 if slot 3 is active, else S4.
- S3:
  - Drive mem_req = 1 with slot 3's latched fields.
  - On mem_ack, capture mem_rdata into res3 if the slot is a load. Next state is S4 if slot 4 is active, else DONE.
  - Without mem_ack, hold all outputs unchanged.
- S4: same as S3 for slot 4. On mem_ack, go to DONE.
- DONE:
  - arb_stall = 0, so the pipeline advances on this edge.
  - wb_rd3 = latched rd3 if slot 3 was a load, else 0. wb_rd4 follows the same rule for slot 4.
  - wb_memdata3 / wb_memdata4 = res3 / res4.
  - Bundle inputs are ignored in this cycle, because they still hold the old bundle. Next state is IDLE.
- wb_rd3 and wb_rd4 are 0 in every state except DONE. wb_memdata3 and wb_memdata4 keep their last values.
- Same-address ordering within one bundle follows slot order, which gives these results:
  - Store3 then Store4 to the same address: memory ends with wdata4.
  - Store3 then Load4 from the same address: the load returns wdata3.
  - Load3 then Store4 to the same address: the load returns the old value.
- mem_ack is ignored in IDLE and DONE.
- mem_req, mem_we, mem_addr and mem_wdata are driven only in S3 and S4. In all other states they are 0.

## Timing
- Reset (rstn = 0, asynchronous): the state goes to IDLE immediately. Every output reads 0, including mem_req, arb_stall, wb_rd* and wb_memdata*. This applies mid-transaction too: any in-flight request is dropped without waiting for ack.
- Stall cycles per bundle, with mem_ack taking k ≥ 1 cycles from the first mem_req cycle:
  - One slot: arb_stall is high for 1 + k cycles.
  - Two slots: arb_stall is high for 1 + k3 + k4 cycles.
  - DONE always adds one non-stall cycle.
- Load result latency: wb_rd* and wb_memdata* are valid exactly one cycle after the ack of the last slot.
- Back-to-back bundles: after DONE there is at least one IDLE cycle before the next S3 or S4.
- No memory request is issued in the IDLE latch cycle. The first mem_req appears on the cycle after the latch cycle.

## Test plan
- Single load, slot 3 only: dec_mre3 = 1, daddr3 = 0x10, memory[0x10] = 0xDEADBEEF, dec_rd3 = 7'h45, ack on the first mem_req cycle.
  - Expect arb_stall high for 2 cycles.
  - Expect one mem_req with addr 0x10 and we = 0.
  - In DONE, expect wb_rd3 = 0x45, wb_memdata3 = 0xDEADBEEF and wb_rd4 = 0.
- Two stores, same address: store3 (0x20, 0x1111) and store4 (0x20, 0x2222).
  - Expect mem_req to carry 0x1111 first, then 0x2222.
  - Expect memory[0x20] = 0x2222 at the end.
  - Expect wb_rd3 = wb_rd4 = 0 in DONE.
- Store then load, same address: store3 (0x30, 0xABCD) and load4 (0x30, rd = 7'h43).
  - Expect wb_memdata4 = 0xABCD and wb_rd4 = 0x43.
- Delayed ack: two loads with ack delayed 3 cycles for each request.
  - Expect arb_stall high for 7 cycles.
  - Expect mem_addr held stable while mem_req is high.
  - Expect results valid in DONE.
- Reset mid-operation: drop rstn during S4 while mem_req is high.
  - Expect mem_req, arb_stall and wb_rd* to go to 0 immediately, without waiting for a clock edge.
  - After release, an empty bundle gives arb_stall = 0.
- Idle bundle: no slot active for 5 cycles.
  - Expect arb_stall = 0, mem_req = 0 and wb_rd* = 0 throughout.
  - Expect a mem_ack pulse during this window to be ignored, with no state change.

Source files
------------

// File: rtl/mem_slot_arbiter.sv
// mem_slot_arbiter
// Sequences VLIW memory slots 3 and 4 of one issued bundle onto a single
// data-memory port. Slot 3 is always issued before slot 4. The pipeline is
// stalled until both slots finish, and then load results are presented for
// writeback for exactly one cycle (DONE).
//
// Ports
//   clk, rstn                        clock, async active-low reset
//   dec_mre3/4, dec_mwe3/4           slot load / store enables (both set = store)
//   daddr3/4, wdata3/4, dec_rd3/4    slot address, store data, load destination
//   arb_stall                        pipeline hold; bundle inputs stay frozen while high
//   mem_req/we/addr/wdata            request to the data memory (nonzero only in S3/S4)
//   mem_ack, mem_rdata               request accepted; load data valid with the ack
//   wb_rd3/4                         writeback destination in DONE, otherwise 0
//   wb_memdata3/4                    load results; they hold until the next DONE
module mem_slot_arbiter #(
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              dec_mre3,
    input  logic              dec_mwe3,
    input  logic              dec_mre4,
    input  logic              dec_mwe4,
    input  logic [ADDR_W-1:0] daddr3,
    input  logic [ADDR_W-1:0] daddr4,
    input  logic [DATA_W-1:0] wdata3,
    input  logic [DATA_W-1:0] wdata4,
    input  logic [6:0]        dec_rd3,
    input  logic [6:0]        dec_rd4,
    output logic              arb_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [6:0]        wb_rd3,
    output logic [6:0]        wb_rd4,
    output logic [DATA_W-1:0] wb_memdata3,
    output logic [DATA_W-1:0] wb_memdata4
);

    localparam int unsigned RD_W = 7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_S3   = 2'd1;
    localparam logic [1:0] ST_S4   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]        state_q, state_d;

    // Latched bundle fields
    logic              act3_q, act3_d, act4_q, act4_d;
    logic              we3_q, we3_d, we4_q, we4_d;
    logic [ADDR_W-1:0] addr3_q, addr3_d, addr4_q, addr4_d;
    logic [DATA_W-1:0] wdat3_q, wdat3_d, wdat4_q, wdat4_d;
    logic [RD_W-1:0]   rd3_q, rd3_d, rd4_q, rd4_d;

    // Load results captured on ack, and the copies shown on the writeback port
    logic [DATA_W-1:0] res3_q, res3_d, res4_q, res4_d;
    logic [DATA_W-1:0] wbd3_q, wbd3_d, wbd4_q, wbd4_d;

    logic              act3_in, act4_in;

    assign act3_in = dec_mre3 | dec_mwe3;
    assign act4_in = dec_mre4 | dec_mwe4;

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            act3_q  <= 1'b0;
            act4_q  <= 1'b0;
            we3_q   <= 1'b0;
            we4_q   <= 1'b0;
            addr3_q <= '0;
            addr4_q <= '0;
            wdat3_q <= '0;
            wdat4_q <= '0;
            rd3_q   <= '0;
            rd4_q   <= '0;
            res3_q  <= '0;
            res4_q  <= '0;
            wbd3_q  <= '0;
            wbd4_q  <= '0;
        end else begin
            state_q <= state_d;
            act3_q  <= act3_d;
            act4_q  <= act4_d;
            we3_q   <= we3_d;
            we4_q   <= we4_d;
            addr3_q <= addr3_d;
            addr4_q <= addr4_d;
            wdat3_q <= wdat3_d;
            wdat4_q <= wdat4_d;
            rd3_q   <= rd3_d;
            rd4_q   <= rd4_d;
            res3_q  <= res3_d;
            res4_q  <= res4_d;
            wbd3_q  <= wbd3_d;
            wbd4_q  <= wbd4_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d   = state_q;
        act3_d    = act3_q;
        act4_d    = act4_q;
        we3_d     = we3_q;
        we4_d     = we4_q;
        addr3_d   = addr3_q;
        addr4_d   = addr4_q;
        wdat3_d   = wdat3_q;
        wdat4_d   = wdat4_q;
        rd3_d     = rd3_q;
        rd4_d     = rd4_q;
        res3_d    = res3_q;
        res4_d    = res4_q;
        wbd3_d    = wbd3_q;
        wbd4_d    = wbd4_q;
        arb_stall = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wb_rd3    = '0;
        wb_rd4    = '0;

        case (state_q)
            ST_IDLE: begin
                if (act3_in || act4_in) begin
                    // The stall depends directly on the inputs in this state, so it is
                    // gated with rstn to keep it at 0 while reset is held.
                    arb_stall = rstn;
                    act3_d    = act3_in;
                    act4_d    = act4_in;
                    we3_d     = dec_mwe3;
                    we4_d     = dec_mwe4;
                    addr3_d   = daddr3;
                    addr4_d   = daddr4;
                    wdat3_d   = wdata3;
                    wdat4_d   = wdata4;
                    rd3_d     = dec_rd3;
                    rd4_d     = dec_rd4;
                    state_d   = act3_in ? ST_S3 : ST_S4;
                end
            end
            ST_S3: begin
                arb_stall = 1'b1;
                mem_req   = 1'b1;
                mem_we    = we3_q;
                mem_addr  = addr3_q;
                mem_wdata = wdat3_q;
                if (mem_ack) begin
                    if (!we3_q) begin
                        res3_d = mem_rdata;
                    end
                    state_d = act4_q ? ST_S4 : ST_DONE;
                end
            end
            ST_S4: begin
                arb_stall = 1'b1;
                mem_req   = 1'b1;
                mem_we    = we4_q;
                mem_addr  = addr4_q;
                mem_wdata = wdat4_q;
                if (mem_ack) begin
                    if (!we4_q) begin
                        res4_d = mem_rdata;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Bundle inputs still show the finished bundle here, so they are not sampled.
                wb_rd3  = (act3_q && !we3_q) ? rd3_q : '0;
                wb_rd4  = (act4_q && !we4_q) ? rd4_q : '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Writeback data changes only when DONE is entered and then holds.
        if (state_d == ST_DONE) begin
            wbd3_d = res3_d;
            wbd4_d = res4_d;
        end
    end

    assign wb_memdata3 = wbd3_q;
    assign wb_memdata4 = wbd4_q;

endmodule
